// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Optional build macro used by the top level: MULDIV_DIVZERO_EN.
package mips_muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mips_muldiv_sign_fix.sv
// Conditional two's-complement negate; converts between signed values and magnitudes.
module mips_muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit writing LO/HI to two regfile ports at once.
// Build macro MULDIV_DIVZERO_EN adds div_by_zero and a short path for zero divisors.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_lo,
  input  logic [4:0]       dest_hi,
  output logic             busy,
  output logic [WIDTH-1:0] write_data,
  output logic [4:0]       write_reg,
  output logic             signal_reg_write,
  output logic [WIDTH-1:0] write_data2,
  output logic [4:0]       write_reg2,
  output logic             signal_reg_write2
`ifdef MULDIV_DIVZERO_EN
  ,
  output logic             div_by_zero
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  op_e                op_q, op_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic               div0_q, div0_d;
  logic [4:0]         dest_lo_q, dest_lo_d;
  logic [4:0]         dest_hi_q, dest_hi_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   wdata2_q, wdata2_d;
  logic [4:0]         wreg_q, wreg_d;
  logic [4:0]         wreg2_q, wreg2_d;
  logic               we_q, we_d;
  logic               we2_q, we2_d;
`ifdef MULDIV_DIVZERO_EN
  logic               dbz_q, dbz_d;
`endif

  op_e              op_in;
  logic             in_signed, in_div, in_a_neg, in_b_neg, in_b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign in_a_neg  = in_signed & operand_a[WIDTH-1];
  assign in_b_neg  = in_signed & operand_b[WIDTH-1];
  assign in_b_zero = (operand_b == '0);

  mips_muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
    .val_i (operand_a),
    .neg_i (in_a_neg),
    .val_o (mag_a)
  );

  mips_muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
    .val_i (operand_b),
    .neg_i (in_b_neg),
    .val_o (mag_b)
  );

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  mips_muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (a_neg_q ^ b_neg_q),
    .val_o (prod_fixed)
  );

  // Zero-divisor quotient is left as all-ones; the remainder still gets a's sign back.
  mips_muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i ((a_neg_q ^ b_neg_q) & ~div0_q),
    .val_o (quo_fixed)
  );

  mips_muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (a_neg_q),
    .val_o (rem_fixed)
  );

  // Multiply step: acc = {partial_hi, multiplier_lo}, add multiplicand then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvsr_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend/quotient}, shift left and trial-subtract.
  logic [WIDTH:0]     rem_sh, trial;
  logic               trial_ok;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, dvsr_q};
  assign trial_ok = (rem_sh >= {1'b0, dvsr_q});
  assign div_next = trial_ok ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvsr_d    = dvsr_q;
    op_d      = op_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    div0_d    = div0_q;
    dest_lo_d = dest_lo_q;
    dest_hi_d = dest_hi_q;
    wdata_d   = wdata_q;
    wdata2_d  = wdata2_q;
    wreg_d    = wreg_q;
    wreg2_d   = wreg2_q;
    we_d      = 1'b0;
    we2_d     = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    dbz_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op_in;
          a_neg_d   = in_a_neg;
          b_neg_d   = in_b_neg;
          div0_d    = in_div & in_b_zero;
          dest_lo_d = dest_lo;
          dest_hi_d = dest_hi;
          dvsr_d    = in_div ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = CALC;
`ifdef MULDIV_DIVZERO_EN
          if (in_div & in_b_zero) begin
            acc_d   = {mag_a, {WIDTH{1'b1}}};
            state_d = FIX;
          end
`endif
        end
      end

      CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      FIX: begin
        if (op_is_div(op_q)) begin
          wdata_d  = quo_fixed;
          wdata2_d = rem_fixed;
        end else begin
          wdata_d  = prod_fixed[WIDTH-1:0];
          wdata2_d = prod_fixed[2*WIDTH-1:WIDTH];
        end
        wreg_d  = dest_lo_q;
        wreg2_d = dest_hi_q;
        we_d    = (dest_lo_q != dest_hi_q);
        we2_d   = 1'b1;
`ifdef MULDIV_DIVZERO_EN
        dbz_d   = div0_q;
`endif
        state_d = WB;
      end

      WB: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvsr_q    <= '0;
      op_q      <= OP_MULT;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      dest_lo_q <= '0;
      dest_hi_q <= '0;
      wdata_q   <= '0;
      wdata2_q  <= '0;
      wreg_q    <= '0;
      wreg2_q   <= '0;
      we_q      <= 1'b0;
      we2_q     <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvsr_q    <= dvsr_d;
      op_q      <= op_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      div0_q    <= div0_d;
      dest_lo_q <= dest_lo_d;
      dest_hi_q <= dest_hi_d;
      wdata_q   <= wdata_d;
      wdata2_q  <= wdata2_d;
      wreg_q    <= wreg_d;
      wreg2_q   <= wreg2_d;
      we_q      <= we_d;
      we2_q     <= we2_d;
`ifdef MULDIV_DIVZERO_EN
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign busy              = (state_q != IDLE);
  assign write_data        = wdata_q;
  assign write_reg         = wreg_q;
  assign signal_reg_write  = we_q;
  assign write_data2       = wdata2_q;
  assign write_reg2        = wreg2_q;
  assign signal_reg_write2 = we2_q;
`ifdef MULDIV_DIVZERO_EN
  assign div_by_zero       = dbz_q;
`endif

endmodule
